// File: rtl/button_controller_if.sv
// Button and display/counter-control signals between the deglitch stage,
// the button controller, and the display/counter blocks.
interface button_controller_if;
    logic       nMode_deglitch;
    logic       nTrip_deglitch;
    logic [1:0] mode;
    logic       units;
    logic       trip_sel;
    logic       mode_step;
    logic       clear_trip;
    logic       clear_all;

    modport master (
        output nMode_deglitch,
        output nTrip_deglitch,
        input  mode,
        input  units,
        input  trip_sel,
        input  mode_step,
        input  clear_trip,
        input  clear_all
    );

    modport slave (
        input  nMode_deglitch,
        input  nTrip_deglitch,
        output mode,
        output units,
        output trip_sel,
        output mode_step,
        output clear_trip,
        output clear_all
    );
endinterface

// File: rtl/button_controller.sv
// Classifies Mode/Trip presses as short, long or combo and drives display
// configuration plus one-cycle clear commands; all outputs registered.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | no button held, waiting for a press
// M_DOWN    | Mode alone held, timing for short/long
// T_DOWN    | Trip alone held, timing for short/long
// BOTH_DOWN | both held, timing for the combo long press
// WAIT_REL  | action decided (or press aborted), waiting for both released
module button_controller #(
    parameter int LONG_PRESS = 32768,
    parameter int MODES      = 4
) (
    input logic               clock,
    input logic               nRst,
    button_controller_if.slave btn
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        M_DOWN    = 3'd1,
        T_DOWN    = 3'd2,
        BOTH_DOWN = 3'd3,
        WAIT_REL  = 3'd4
    } state_t;

    localparam logic [15:0] HOLD_MAX  = 16'(LONG_PRESS - 1);
    localparam logic [1:0]  MODE_LAST = 2'(MODES - 1);

    state_t      state;
    state_t      nextState;
    logic [15:0] holdCnt;

    logic [1:0]  modeReg;
    logic        unitsReg;
    logic        tripSelReg;
    logic        stepReg;
    logic        clrTripReg;
    logic        clrAllReg;

    logic [1:0]  modeNext;
    logic        unitsNext;
    logic        tripSelNext;
    logic        stepNext;
    logic        clrTripNext;
    logic        clrAllNext;

    logic        modeDown;
    logic        tripDown;
    logic        isLong;
    logic        timing;

    assign modeDown = ~btn.nMode_deglitch;
    assign tripDown = ~btn.nTrip_deglitch;
    // The long condition takes priority over a release or second press in the same cycle.
    assign isLong   = (holdCnt == HOLD_MAX);
    assign timing   = (state == M_DOWN) || (state == T_DOWN) || (state == BOTH_DOWN);

    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            state      <= IDLE;
            holdCnt    <= '0;
            modeReg    <= '0;
            unitsReg   <= 1'b0;
            tripSelReg <= 1'b0;
            stepReg    <= 1'b0;
            clrTripReg <= 1'b0;
            clrAllReg  <= 1'b0;
        end else begin
            state      <= nextState;
            modeReg    <= modeNext;
            unitsReg   <= unitsNext;
            tripSelReg <= tripSelNext;
            stepReg    <= stepNext;
            clrTripReg <= clrTripNext;
            clrAllReg  <= clrAllNext;
            if (nextState != state) begin
                holdCnt <= '0;
            end else if (timing && !isLong) begin
                holdCnt <= holdCnt + 16'd1;
            end
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (modeDown && tripDown) begin
                    nextState = BOTH_DOWN;
                end else if (modeDown) begin
                    nextState = M_DOWN;
                end else if (tripDown) begin
                    nextState = T_DOWN;
                end
            end
            M_DOWN: begin
                if (isLong) begin
                    nextState = WAIT_REL;
                end else if (tripDown) begin
                    nextState = BOTH_DOWN;
                end else if (!modeDown) begin
                    nextState = IDLE;
                end
            end
            T_DOWN: begin
                if (isLong) begin
                    nextState = WAIT_REL;
                end else if (modeDown) begin
                    nextState = BOTH_DOWN;
                end else if (!tripDown) begin
                    nextState = IDLE;
                end
            end
            BOTH_DOWN: begin
                if (isLong || !modeDown || !tripDown) begin
                    nextState = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (!modeDown && !tripDown) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        modeNext    = modeReg;
        unitsNext   = unitsReg;
        tripSelNext = tripSelReg;
        stepNext    = 1'b0;
        clrTripNext = 1'b0;
        clrAllNext  = 1'b0;
        case (state)
            M_DOWN: begin
                if (isLong) begin
                    unitsNext = ~unitsReg;
                end else if (!tripDown && !modeDown) begin
                    stepNext = 1'b1;
                    modeNext = (modeReg == MODE_LAST) ? 2'd0 : modeReg + 2'd1;
                end
            end
            T_DOWN: begin
                if (isLong) begin
                    clrTripNext = 1'b1;
                end else if (!modeDown && !tripDown) begin
                    tripSelNext = ~tripSelReg;
                end
            end
            BOTH_DOWN: begin
                if (isLong) begin
                    clrAllNext = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    assign btn.mode       = modeReg;
    assign btn.units      = unitsReg;
    assign btn.trip_sel   = tripSelReg;
    assign btn.mode_step  = stepReg;
    assign btn.clear_trip = clrTripReg;
    assign btn.clear_all  = clrAllReg;
endmodule

// File: tb/tb_button_controller.sv
// Directed bench for button_controller: table of press phases with
// hand-computed results, plus exact-timing sequences for the corner cases.
module tb_button_controller;
    localparam int LP = 1000;

    typedef struct {
        logic       nM;
        logic       nT;
        int         cycles;
        logic [1:0] mode;
        logic       units;
        logic       tripSel;
        int         steps;
        int         clrTrips;
        int         clrAlls;
    } vec_t;

    logic clock;
    logic nRst;
    int   total;
    int   bad;
    int   nStep;
    int   nClrTrip;
    int   nClrAll;
    int   multi;

    button_controller_if btn();

    button_controller #(.LONG_PRESS(LP), .MODES(4)) dut (
        .clock(clock),
        .nRst (nRst),
        .btn  (btn)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clearCounts();
        nStep    = 0;
        nClrTrip = 0;
        nClrAll  = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (btn.mode_step === 1'b1) nStep++;
        if (btn.clear_trip === 1'b1) nClrTrip++;
        if (btn.clear_all === 1'b1) nClrAll++;
        if (int'(btn.mode_step) + int'(btn.clear_trip) + int'(btn.clear_all) > 1) multi++;
    endtask

    task automatic waitClrTrip(input int limit, output int edges);
        edges = -1;
        for (int k = 1; k <= limit; k++) begin
            tick();
            if (btn.clear_trip === 1'b1) begin
                edges = k;
                break;
            end
        end
    endtask

    function automatic vec_t row(input logic nM, input logic nT, input int cyc,
                                 input logic [1:0] md, input logic un, input logic ts,
                                 input int st, input int ct, input int ca);
        vec_t v;
        v.nM = nM; v.nT = nT; v.cycles = cyc;
        v.mode = md; v.units = un; v.tripSel = ts;
        v.steps = st; v.clrTrips = ct; v.clrAlls = ca;
        return v;
    endfunction

    vec_t vecs[$];
    int   edges;

    initial begin
        total = 0; bad = 0; multi = 0;
        clearCounts();

        // short Mode presses: 0 -> 1 -> 2 -> 3 -> 0
        vecs.push_back(row(0, 1, 100,    2'd0, 0, 0, 0, 0, 0));
        vecs.push_back(row(1, 1, 3,      2'd1, 0, 0, 1, 0, 0));
        vecs.push_back(row(0, 1, 100,    2'd1, 0, 0, 0, 0, 0));
        vecs.push_back(row(1, 1, 3,      2'd2, 0, 0, 1, 0, 0));
        vecs.push_back(row(0, 1, 100,    2'd2, 0, 0, 0, 0, 0));
        vecs.push_back(row(1, 1, 3,      2'd3, 0, 0, 1, 0, 0));
        vecs.push_back(row(0, 1, 100,    2'd3, 0, 0, 0, 0, 0));
        vecs.push_back(row(1, 1, 3,      2'd0, 0, 0, 1, 0, 0));
        // short Trip presses toggle trip_sel
        vecs.push_back(row(1, 0, 500,    2'd0, 0, 0, 0, 0, 0));
        vecs.push_back(row(1, 1, 3,      2'd0, 0, 1, 0, 0, 0));
        vecs.push_back(row(1, 0, 500,    2'd0, 0, 1, 0, 0, 0));
        vecs.push_back(row(1, 1, 3,      2'd0, 0, 0, 0, 0, 0));
        // long Trip
        vecs.push_back(row(1, 0, LP + 10, 2'd0, 0, 0, 0, 1, 0));
        vecs.push_back(row(1, 1, 3,      2'd0, 0, 0, 0, 0, 0));
        // long Mode, then Trip during WAIT_REL
        vecs.push_back(row(0, 1, LP + 5, 2'd0, 1, 0, 0, 0, 0));
        vecs.push_back(row(0, 0, 20,     2'd0, 1, 0, 0, 0, 0));
        vecs.push_back(row(1, 1, 3,      2'd0, 1, 0, 0, 0, 0));
        // combo long
        vecs.push_back(row(0, 1, 50,     2'd0, 1, 0, 0, 0, 0));
        vecs.push_back(row(0, 0, LP + 10, 2'd0, 1, 0, 0, 0, 1));
        vecs.push_back(row(1, 1, 3,      2'd0, 1, 0, 0, 0, 0));
        // combo aborted by Trip release after 200
        vecs.push_back(row(0, 1, 50,     2'd0, 1, 0, 0, 0, 0));
        vecs.push_back(row(0, 0, 200,    2'd0, 1, 0, 0, 0, 0));
        vecs.push_back(row(0, 1, 10,     2'd0, 1, 0, 0, 0, 0));
        vecs.push_back(row(1, 1, 3,      2'd0, 1, 0, 0, 0, 0));
        // set mode=1, trip_sel=1 for later sequences
        vecs.push_back(row(0, 1, 100,    2'd0, 1, 0, 0, 0, 0));
        vecs.push_back(row(1, 1, 3,      2'd1, 1, 0, 1, 0, 0));
        vecs.push_back(row(1, 0, 100,    2'd1, 1, 0, 0, 0, 0));
        vecs.push_back(row(1, 1, 3,      2'd1, 1, 1, 0, 0, 0));

        nRst = 1'b0;
        btn.nMode_deglitch = 1'b1;
        btn.nTrip_deglitch = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("reset mode", 32'(btn.mode), 0);
        check("reset units", 32'(btn.units), 0);
        check("reset trip_sel", 32'(btn.trip_sel), 0);
        check("reset pulses", 32'({btn.mode_step, btn.clear_trip, btn.clear_all}), 0);
        nRst = 1'b1;
        repeat (2) tick();

        foreach (vecs[i]) begin
            clearCounts();
            btn.nMode_deglitch = vecs[i].nM;
            btn.nTrip_deglitch = vecs[i].nT;
            repeat (vecs[i].cycles) tick();
            check($sformatf("row%0d mode", i), 32'(btn.mode), 32'(vecs[i].mode));
            check($sformatf("row%0d units", i), 32'(btn.units), 32'(vecs[i].units));
            check($sformatf("row%0d trip_sel", i), 32'(btn.trip_sel), 32'(vecs[i].tripSel));
            check($sformatf("row%0d mode_step count", i), 32'(nStep), 32'(vecs[i].steps));
            check($sformatf("row%0d clear_trip count", i), 32'(nClrTrip), 32'(vecs[i].clrTrips));
            check($sformatf("row%0d clear_all count", i), 32'(nClrAll), 32'(vecs[i].clrAlls));
        end

        // mode_step exactly one cycle after release, one cycle wide
        btn.nMode_deglitch = 1'b0;
        repeat (100) tick();
        btn.nMode_deglitch = 1'b1;
        tick();
        check("short mode_step edge", 32'(btn.mode_step), 1);
        check("short mode value", 32'(btn.mode), 2);
        tick();
        check("short mode_step width", 32'(btn.mode_step), 0);
        repeat (2) tick();

        // Trip released in the same cycle as long: long wins
        btn.nTrip_deglitch = 1'b0;
        repeat (LP) tick();
        check("trip pre-long clear_trip", 32'(btn.clear_trip), 0);
        btn.nTrip_deglitch = 1'b1;
        tick();
        check("trip release-at-long clear_trip", 32'(btn.clear_trip), 1);
        check("trip release-at-long trip_sel", 32'(btn.trip_sel), 1);
        tick();
        check("trip release-at-long width", 32'(btn.clear_trip), 0);
        repeat (3) tick();

        // Trip arrives in the same cycle as Mode long: units toggles, no combo
        btn.nMode_deglitch = 1'b0;
        repeat (LP) tick();
        check("mode pre-long units", 32'(btn.units), 1);
        btn.nTrip_deglitch = 1'b0;
        tick();
        check("mode long+trip units", 32'(btn.units), 0);
        check("mode long+trip mode", 32'(btn.mode), 2);
        clearCounts();
        repeat (LP + 20) tick();
        btn.nMode_deglitch = 1'b1;
        btn.nTrip_deglitch = 1'b1;
        repeat (3) tick();
        check("mode long+trip clear_all count", 32'(nClrAll), 0);
        check("mode long+trip mode_step count", 32'(nStep), 0);

        // reset mid-press, then Trip held across reset release
        btn.nTrip_deglitch = 1'b0;
        repeat (LP - 5) tick();
        check("pre-reset trip_sel", 32'(btn.trip_sel), 1);
        nRst = 1'b0;
        #1;
        check("mid-press reset mode", 32'(btn.mode), 0);
        check("mid-press reset units", 32'(btn.units), 0);
        check("mid-press reset trip_sel", 32'(btn.trip_sel), 0);
        check("mid-press reset clear_trip", 32'(btn.clear_trip), 0);
        repeat (2) @(posedge clock);
        #1;
        nRst = 1'b1;
        clearCounts();
        waitClrTrip(2 * LP, edges);
        check("post-reset clear_trip latency", 32'(edges), 32'(LP + 1));
        clearCounts();
        repeat (20) tick();
        btn.nTrip_deglitch = 1'b1;
        repeat (3) tick();
        check("post-reset clear_trip repeat", 32'(nClrTrip), 0);
        check("post-reset trip_sel", 32'(btn.trip_sel), 0);

        check("one pulse per cycle", 32'(multi), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
